q2fsm_rr_scheduler: RTL and testbench
=====================================

Name: q2fsm_rr_scheduler

Overview:
- Time-multiplexed controller that shares one six-state w-sequence detector (next-state/z logic) among NCH independent bit-serial channels.
- Keeps per-channel state in a register table.
- A round-robin arbiter grants one channel per cycle; the shared logic advances that channel's state and reports z.
- Sits between the per-lane sampling front-ends and the event-collection logic.

Parameters:
- NCH, 4, number of requesting channels (2..16)
- CW, $clog2(NCH), channel index width (derived, not overridable)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  NCH  per-channel sample valid
- req_w  input  NCH  per-channel sample bit w
- req_ready  output  NCH  one-hot accept; combinational from req_valid, chan_clr and rr pointer
- chan_clr  input  NCH  per-channel clear: state returns to A
- z_valid  output  1  registered; pulses one cycle after an accept
- z_ch  output  CW  channel of the reported result
- z  output  1  z of that channel's new state
- z_vec  output  NCH  registered current z of every channel

Behaviour:
- Reset is clk: reset, synchronous, active-high.
- Values during reset:
  - all channel states = A
  - rr pointer = 0
  - z_valid = 0, z_ch = 0, z = 0, z_vec = 0
  - req_ready = 0 while reset is high
- State encodings A=0, B=1, C=2, D=3, E=4, F=5. Codes 6/7 are unreachable; if one is present, next state = A.
- Transitions (w=1 / w=0):
  - A: B / A
  - B: C / D
  - C: E / D
  - D: F / A
  - E: E / D
  - F: C / D
- z = 1 iff the state is E or F.
- Arbitration:
  - Eligible channels: req_valid=1 and chan_clr=0.
  - Grant goes to the first eligible channel at or after the rr pointer, wrapping modulo NCH.
  - req_ready is one-hot on the granted channel, or all zero if none is eligible.
  - Accept means req_valid & req_ready.
- On an accept of channel k with sample w:
  - state[k] <= next(state[k], w)
  - the rr pointer <= (k+1) mod NCH
  - next cycle: z_valid=1, z_ch=k, z = z of the new state, z_vec[k] updated
- No accept:
  - z_valid=0 next cycle
  - z_ch and z hold their last values
  - the rr pointer holds
- Latency: exactly 1 cycle from accept to z_valid. Throughput is 1 sample/cycle across all channels.
- chan_clr[k]:
  - state[k] <= A and z_vec[k] <= 0 next cycle
  - channel k is not granted that cycle, and its pending sample is not consumed (the requester keeps valid)
  - other channels are unaffected and may be granted the same cycle
- A channel not granted keeps its state; samples are never dropped or reordered. The requester holds req_valid/req_w until ready.
- Reset mid-operation: all states return to A and pending results are discarded (z_valid=0). The first post-reset grant goes to channel 0 if it is eligible.

Optional Feature:
- Macro: Q2FSM_HIT_CNT_EN.
- Defined:
  - Adds input rd_ch (CW bits) and output hit_cnt (8 bits).
  - Each channel gets an 8-bit saturating counter (max 255) that increments when an accept moves that channel from a z=0 state to a z=1 state.
  - chan_clr[k] or reset zeroes the counter.
  - hit_cnt = the counter of rd_ch, registered with 1-cycle read latency.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package q2fsm_pkg holds:
  - the state typedef (3-bit enum A..F)
  - the state encodings
  - a next_state(state, w) function
  - an is_z(state) function
  - the hit-counter width constant (8)
- Sub-module rr_arbiter (NCH parameter) has inputs req vector and pointer, and outputs one-hot grant and grant index. Because it is purely combinational, the pointer register stays in the parent.

Test Plan:
1. Reset, then channel 0 alone streams w = 1,1,1,0,1.
   - Expect z_valid each cycle after an accept, with z = 0,0,1,0,1.
   - Expect the state sequence B,C,E,D,F.
2. All 4 channels hold valid continuously.
   - Expect grants 0,1,2,3,0,… on consecutive cycles.
   - Expect z_ch to follow, each with 1-cycle latency.
3. Channel 2 reaches E (w=1,1,1), then chan_clr[2] is asserted while req_valid[2]=1.
   - Expect no grant to channel 2 that cycle and z_vec[2]=0 next cycle.
   - After clear deasserts, w=1 moves channel 2 to B (z=0).
4. Channel 1 reaches F (w=1,0,1), then synchronous reset is asserted for 1 cycle.
   - Expect z_vec=0 and z_valid=0.
   - A following w=1 on channel 1 yields B (z=0).
5. Requests on channels 1 and 3 only, with the pointer at 2.
   - Expect 3 granted first, then 1, then 3.
   - Expect no valid result for idle channels.
6. With Q2FSM_HIT_CNT_EN, channel 0 toggles between D and F 300 times (w=1,0 repeated after 1,0).
   - Expect hit_cnt for rd_ch=0 to saturate at 255.
   - chan_clr[0] returns it to 0.

Source files
------------

// File: rtl/q2fsm_pkg.sv
// Shared definitions for the time-multiplexed w-sequence detector:
// state encoding, next-state/z logic and the hit-counter width.
package q2fsm_pkg;

  typedef enum logic [2:0] {
    ST_A = 3'd0,
    ST_B = 3'd1,
    ST_C = 3'd2,
    ST_D = 3'd3,
    ST_E = 3'd4,
    ST_F = 3'd5
  } state_t;

  localparam int HIT_CNT_W = 8;

  // Codes 6/7 cannot be reached; if one ever appears it recovers to A.
  function automatic state_t next_state(input state_t s, input logic w);
    case (s)
      ST_A:    next_state = w ? ST_B : ST_A;
      ST_B:    next_state = w ? ST_C : ST_D;
      ST_C:    next_state = w ? ST_E : ST_D;
      ST_D:    next_state = w ? ST_F : ST_A;
      ST_E:    next_state = w ? ST_E : ST_D;
      ST_F:    next_state = w ? ST_C : ST_D;
      default: next_state = ST_A;
    endcase
  endfunction

  function automatic logic is_z(input state_t s);
    is_z = (s == ST_E) || (s == ST_F);
  endfunction

endpackage

// File: rtl/q2fsm_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping modulo NCH. The pointer register lives in the parent.
module rr_arbiter #(
  parameter  int NCH = 4,
  localparam int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [NCH-1:0] grant,
  output logic [CW-1:0]  grant_idx
);

  logic found;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      int j;
      j = (int'(ptr) + i) % NCH;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = CW'(j);
      end
    end
  end

endmodule

// File: rtl/q2fsm_rr_scheduler.sv
// Shares one six-state w-sequence detector among NCH bit-serial channels via
// round-robin grants. Define Q2FSM_HIT_CNT_EN to add per-channel hit counters.
module q2fsm_rr_scheduler
  import q2fsm_pkg::*;
#(
  parameter  int NCH = 4,
  localparam int CW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       req_valid,
  input  logic [NCH-1:0]       req_w,
  output logic [NCH-1:0]       req_ready,
  input  logic [NCH-1:0]       chan_clr,
  output logic                 z_valid,
  output logic [CW-1:0]        z_ch,
  output logic                 z,
  output logic [NCH-1:0]       z_vec
`ifdef Q2FSM_HIT_CNT_EN
  ,
  input  logic [CW-1:0]        rd_ch,
  output logic [HIT_CNT_W-1:0] hit_cnt
`endif
);

  state_t         st [NCH];
  logic [CW-1:0]  ptr;
  logic [NCH-1:0] eligible;
  logic [NCH-1:0] grant;
  logic [CW-1:0]  gidx;
  logic           acc_any;
  state_t         cur_st;
  state_t         nxt_st;

  // A channel being cleared must keep its pending sample for later.
  assign eligible = req_valid & ~chan_clr;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req       (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign req_ready = reset ? '0 : grant;
  assign acc_any   = |(req_valid & req_ready);
  assign cur_st    = st[gidx];
  assign nxt_st    = next_state(cur_st, req_w[gidx]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the state table is reset explicitly because every channel must
      // restart in A; plain storage arrays normally would not be reset.
      for (int k = 0; k < NCH; k++) st[k] <= ST_A;
      ptr     <= '0;
      z_valid <= 1'b0;
      z_ch    <= '0;
      z       <= 1'b0;
      z_vec   <= '0;
    end else begin
      z_valid <= acc_any;
      if (acc_any) begin
        st[gidx]    <= nxt_st;
        ptr         <= (gidx == CW'(NCH - 1)) ? '0 : gidx + 1'b1;
        z_ch        <= gidx;
        z           <= is_z(nxt_st);
        z_vec[gidx] <= is_z(nxt_st);
      end
      // A cleared channel is never granted, so this cannot collide with the accept.
      for (int k = 0; k < NCH; k++) begin
        if (chan_clr[k]) begin
          st[k]    <= ST_A;
          z_vec[k] <= 1'b0;
        end
      end
    end
  end

`ifdef Q2FSM_HIT_CNT_EN
  logic [HIT_CNT_W-1:0] cnt [NCH];
  logic                 hit;

  assign hit = acc_any && !is_z(cur_st) && is_z(nxt_st);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) cnt[k] <= '0;
      hit_cnt <= '0;
    end else begin
      if (hit && cnt[gidx] != {HIT_CNT_W{1'b1}}) cnt[gidx] <= cnt[gidx] + 1'b1;
      for (int k = 0; k < NCH; k++) begin
        if (chan_clr[k]) cnt[k] <= '0;
      end
      hit_cnt <= (int'(rd_ch) < NCH) ? cnt[rd_ch] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_q2fsm_rr_scheduler.sv
// Directed self-checking bench for q2fsm_rr_scheduler (NCH=4); the hit-counter
// scenario runs only when Q2FSM_HIT_CNT_EN is defined.
module tb_q2fsm_rr_scheduler;

  localparam int NCH = 4;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] req_valid;
  logic [NCH-1:0] req_w;
  logic [NCH-1:0] req_ready;
  logic [NCH-1:0] chan_clr;
  logic           z_valid;
  logic [CW-1:0]  z_ch;
  logic           z;
  logic [NCH-1:0] z_vec;
`ifdef Q2FSM_HIT_CNT_EN
  logic [CW-1:0]  rd_ch;
  logic [7:0]     hit_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  q2fsm_rr_scheduler #(.NCH(NCH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_w     (req_w),
    .req_ready (req_ready),
    .chan_clr  (chan_clr),
    .z_valid   (z_valid),
    .z_ch      (z_ch),
    .z         (z),
    .z_vec     (z_vec)
`ifdef Q2FSM_HIT_CNT_EN
    ,
    .rd_ch     (rd_ch),
    .hit_cnt   (hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs, then let the combinational ready settle before it is checked.
  task automatic drive(input logic [NCH-1:0] v, input logic [NCH-1:0] w,
                       input logic [NCH-1:0] c);
    req_valid = v;
    req_w     = w;
    chan_clr  = c;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive('0, '0, '0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(4'b1111, 4'b1111, '0);
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    tick();
    tick();
    checks++;
    if ({z_valid, z_ch, z, z_vec} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got z_valid=%b z_ch=%0d z=%b z_vec=%b exp all 0",
               z_valid, z_ch, z, z_vec);
    end
    reset = 1'b0;
    drive('0, '0, '0);
  endtask

  // Channel 0 alone: w=1,1,1,0,1 walks A->B->C->E->D->F, z=0,0,1,0,1.
  task automatic test_single_stream();
    logic [4:0] w_seq = 5'b10111;
    logic [4:0] z_seq = 5'b10100;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0001, {3'b000, w_seq[i]}, '0);
      checks++;
      if (req_ready !== 4'b0001) begin
        failures++; $display("FAIL single_ready[%0d] got=%b exp=0001", i, req_ready);
      end
      tick();
      checks++;
      if (z_valid !== 1'b1 || z_ch !== 2'd0 || z !== z_seq[i]) begin
        failures++;
        $display("FAIL single_result[%0d] got v=%b ch=%0d z=%b exp v=1 ch=0 z=%b",
                 i, z_valid, z_ch, z, z_seq[i]);
      end
    end
    checks++;
    if (z_vec !== 4'b0001) begin
      failures++; $display("FAIL single_zvec got=%b exp=0001", z_vec);
    end
    drive('0, '0, '0);
    tick();
    checks++;
    if (z_valid !== 1'b0 || z_ch !== 2'd0 || z !== 1'b1) begin
      failures++;
      $display("FAIL single_idle_hold got v=%b ch=%0d z=%b exp v=0 ch=0 z=1", z_valid, z_ch, z);
    end
  endtask

  // All channels valid with w=0: grants rotate 0,1,2,3,0,1,2,3.
  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      logic [NCH-1:0] exp_rdy;
      exp_rdy = 4'b0001 << (i % NCH);
      drive(4'b1111, 4'b0000, '0);
      checks++;
      if (req_ready !== exp_rdy) begin
        failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, req_ready, exp_rdy);
      end
      tick();
      checks++;
      if (z_valid !== 1'b1 || z_ch !== CW'(i % NCH) || z !== 1'b0) begin
        failures++;
        $display("FAIL rr_result[%0d] got v=%b ch=%0d z=%b exp v=1 ch=%0d z=0",
                 i, z_valid, z_ch, z, i % NCH);
      end
    end
    drive('0, '0, '0);
  endtask

  // Channel 2 reaches E, is cleared while ch0 is granted, then restarts from A.
  task automatic test_chan_clr();
    logic [2:0] z_after = 3'b100;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 4'b0100, '0);
      tick();
    end
    checks++;
    if (z !== 1'b1 || z_vec !== 4'b0100) begin
      failures++; $display("FAIL clr_reach_e got z=%b z_vec=%b exp z=1 z_vec=0100", z, z_vec);
    end
    // Pointer is 3; ch2 is cleared, so ch0 wins by wrapping.
    drive(4'b0101, 4'b0101, 4'b0100);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL clr_ready got=%b exp=0001", req_ready);
    end
    tick();
    checks++;
    if (z_vec !== 4'b0000 || z_valid !== 1'b1 || z_ch !== 2'd0 || z !== 1'b0) begin
      failures++;
      $display("FAIL clr_result got z_vec=%b v=%b ch=%0d z=%b exp z_vec=0000 v=1 ch=0 z=0",
               z_vec, z_valid, z_ch, z);
    end
    // From A: w=1,1,1 gives B,C,E with z=0,0,1.
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 4'b0100, '0);
      checks++;
      if (req_ready !== 4'b0100) begin
        failures++; $display("FAIL clr_restart_ready[%0d] got=%b exp=0100", i, req_ready);
      end
      tick();
      checks++;
      if (z_valid !== 1'b1 || z_ch !== 2'd2 || z !== z_after[i]) begin
        failures++;
        $display("FAIL clr_restart[%0d] got v=%b ch=%0d z=%b exp v=1 ch=2 z=%b",
                 i, z_valid, z_ch, z, z_after[i]);
      end
    end
    drive('0, '0, '0);
  endtask

  // Channel 1 reaches F, then a one-cycle reset discards the pending result.
  task automatic test_mid_reset();
    logic [2:0] w_seq = 3'b101;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0010, {2'b00, w_seq[i], 1'b0}, '0);
      tick();
    end
    checks++;
    if (z_valid !== 1'b1 || z !== 1'b1 || z_vec !== 4'b0010) begin
      failures++;
      $display("FAIL mid_reach_f got v=%b z=%b z_vec=%b exp v=1 z=1 z_vec=0010", z_valid, z, z_vec);
    end
    reset = 1'b1;
    drive(4'b0010, 4'b0010, '0);
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL mid_reset_ready got=%b exp=0000", req_ready);
    end
    tick();
    checks++;
    if (z_valid !== 1'b0 || z_vec !== 4'b0000) begin
      failures++; $display("FAIL mid_reset_out got v=%b z_vec=%b exp v=0 z_vec=0000", z_valid, z_vec);
    end
    reset = 1'b0;
    // From A: w=1 gives B (z=0), a second w=1 gives C (z=0).
    for (int i = 0; i < 2; i++) begin
      drive(4'b0010, 4'b0010, '0);
      tick();
      checks++;
      if (z_valid !== 1'b1 || z_ch !== 2'd1 || z !== 1'b0) begin
        failures++;
        $display("FAIL mid_after[%0d] got v=%b ch=%0d z=%b exp v=1 ch=1 z=0", i, z_valid, z_ch, z);
      end
    end
    drive('0, '0, '0);
  endtask

  // Pointer set to 2, then channels 1 and 3 compete: 3, 1, 3.
  task automatic test_sparse_requests();
    logic [1:0] exp_ch [3] = '{2'd3, 2'd1, 2'd3};
    do_reset();
    drive(4'b0010, 4'b0000, '0);
    tick();
    for (int i = 0; i < 3; i++) begin
      logic [NCH-1:0] exp_rdy;
      exp_rdy = 4'b0001 << exp_ch[i];
      drive(4'b1010, 4'b0000, '0);
      checks++;
      if (req_ready !== exp_rdy) begin
        failures++; $display("FAIL sparse_ready[%0d] got=%b exp=%b", i, req_ready, exp_rdy);
      end
      tick();
      checks++;
      if (z_valid !== 1'b1 || z_ch !== exp_ch[i]) begin
        failures++;
        $display("FAIL sparse_result[%0d] got v=%b ch=%0d exp v=1 ch=%0d", i, z_valid, z_ch, exp_ch[i]);
      end
    end
    drive('0, '0, '0);
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL sparse_idle_ready got=%b exp=0000", req_ready);
    end
    tick();
    checks++;
    if (z_valid !== 1'b0 || z_ch !== 2'd3) begin
      failures++; $display("FAIL sparse_idle got v=%b ch=%0d exp v=0 ch=3", z_valid, z_ch);
    end
  endtask

`ifdef Q2FSM_HIT_CNT_EN
  task automatic send_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      drive(4'b0001, 4'b0001, '0);
      tick();
      drive(4'b0001, 4'b0000, '0);
      tick();
    end
    drive('0, '0, '0);
    tick();
    tick();
  endtask

  // Channel 0 goes A->B->D, then each (1,0) pair is D->F (hit) -> D.
  task automatic test_hit_cnt();
    rd_ch = 2'd0;
    do_reset();
    drive(4'b0001, 4'b0001, '0);
    tick();
    drive(4'b0001, 4'b0000, '0);
    tick();
    send_pairs(10);
    checks++;
    if (hit_cnt !== 8'd10) begin
      failures++; $display("FAIL hit_cnt_10 got=%0d exp=10", hit_cnt);
    end
    send_pairs(290);
    checks++;
    if (hit_cnt !== 8'd255) begin
      failures++; $display("FAIL hit_cnt_sat got=%0d exp=255", hit_cnt);
    end
    rd_ch = 2'd1;
    tick();
    checks++;
    if (hit_cnt !== 8'd0) begin
      failures++; $display("FAIL hit_cnt_other got=%0d exp=0", hit_cnt);
    end
    rd_ch = 2'd0;
    drive('0, '0, 4'b0001);
    tick();
    drive('0, '0, '0);
    tick();
    checks++;
    if (hit_cnt !== 8'd0) begin
      failures++; $display("FAIL hit_cnt_clr got=%0d exp=0", hit_cnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_w = '0;
    chan_clr = '0;
`ifdef Q2FSM_HIT_CNT_EN
    rd_ch = '0;
`endif
    #2;
    test_reset();
    test_single_stream();
    test_round_robin();
    test_chan_clr();
    test_mid_reset();
    test_sparse_requests();
`ifdef Q2FSM_HIT_CNT_EN
    test_hit_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
